// File: rtl/lms_ctr_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lms_ctr_onchip_mem_arbiter
//
// Two-master round-robin arbiter in front of the single-port on-chip RAM.
// Master 0 is the NIOS data master and master 1 is the FPGA-side helper
// master. A granted transfer is accepted in the same cycle with no wait
// states. Read data comes back from the RAM one cycle after the read is
// issued and is tagged to the master that issued it.
//
// Fairness: while the other master is requesting, the current owner keeps
// the port for at most MAX_HOLD consecutive grants. With no contention the
// owner keeps the port for as long as it keeps requesting.
//
// Ports
//   clk                  system clock, rising edge
//   reset                asynchronous active-high reset
//   m{0,1}_address       word address from the master
//   m{0,1}_byteenable    byte enables from the master
//   m{0,1}_read          read request
//   m{0,1}_write         write request (takes priority over a read)
//   m{0,1}_writedata     write data
//   m{0,1}_waitrequest   1 = request not accepted this cycle
//   m{0,1}_readdata      shared read data bus, qualified by readdatavalid
//   m{0,1}_readdatavalid one-cycle pulse returning that master's read data
//   mem_address          RAM address
//   mem_byteenable       RAM byte enables
//   mem_chipselect       RAM chipselect, high only on an accepted transfer
//   mem_write            RAM write strobe
//   mem_writedata        RAM write data
//   mem_clken            RAM clock enable, low while reset is asserted
//   mem_readdata         RAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module lms_ctr_onchip_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Master-side signals gathered into arrays so the grant mux and the
  // per-master outputs can be written once for both masters.
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_arr  [2];
  logic [BE_W-1:0]   be_arr    [2];
  logic [DATA_W-1:0] wdata_arr [2];
  logic [1:0]        rd_vec;
  logic [1:0]        wr_vec;
  logic [1:0]        req;
  logic [1:0]        wait_vec;
  logic [1:0]        valid_vec;

  assign addr_arr[0]  = m0_address;
  assign addr_arr[1]  = m1_address;
  assign be_arr[0]    = m0_byteenable;
  assign be_arr[1]    = m1_byteenable;
  assign wdata_arr[0] = m0_writedata;
  assign wdata_arr[1] = m1_writedata;
  assign rd_vec       = {m1_read, m0_read};
  assign wr_vec       = {m1_write, m0_write};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rr_reg, rr_next;       // master preferred on a tie in IDLE
  logic             rd_pend_reg;           // a read was issued last cycle
  logic             rd_id_reg;             // ...by this master

  // Grant decision (from next-state logic) and its reset-qualified form
  logic             gnt_valid;
  logic             gnt_id;
  logic             gnt_ok;
  logic             rd_accept;

  // -------------------------------------------------------------------------
  // Process 1: state register. The read pipe is cleared on reset so a read
  // that was in flight never produces a readdatavalid pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= CNT_ZERO;
      rr_reg      <= 1'b0;
      rd_pend_reg <= 1'b0;
      rd_id_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rr_reg      <= rr_next;
      rd_pend_reg <= rd_accept;
      rd_id_reg   <= gnt_id;
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: grant decision and next state.
  // 'cont' marks a grant that continues the current ownership; only those
  // advance the hold counter, a change of owner restarts it at one.
  // -------------------------------------------------------------------------
  logic own_id;
  logic cont;

  always_comb begin
    gnt_valid  = 1'b0;
    gnt_id     = 1'b0;
    cont       = 1'b0;
    own_id     = (state_reg == OWN1);
    state_next = IDLE;
    cnt_next   = CNT_ZERO;
    rr_next    = rr_reg;

    unique case (state_reg)
      IDLE: begin
        if (req[0] && req[1]) begin
          gnt_valid = 1'b1;
          gnt_id    = rr_reg;
        end else if (req[0]) begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b0;
        end else if (req[1]) begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b1;
        end
      end

      OWN0, OWN1: begin
        // The owner keeps the port unless the other master is waiting and
        // the owner has already used up its MAX_HOLD grants.
        if (req[own_id] && (!req[~own_id] || (cnt_reg < CNT_MAX))) begin
          gnt_valid = 1'b1;
          gnt_id    = own_id;
          cont      = 1'b1;
        end else if (req[~own_id]) begin
          gnt_valid = 1'b1;
          gnt_id    = ~own_id;
        end
      end

      default: begin
        gnt_valid = 1'b0;
      end
    endcase

    if (gnt_valid) begin
      state_next = gnt_id ? OWN1 : OWN0;
      if (cont) begin
        // Saturate so a lone master streaming forever cannot wrap the count
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : (cnt_reg + CNT_ONE);
      end else begin
        cnt_next = CNT_ONE;
      end
      rr_next = ~gnt_id;
    end
  end

  // -------------------------------------------------------------------------
  // Process 3: outputs. Nothing is granted while reset is held, so both
  // masters see waitrequest and the RAM sees no chipselect.
  // -------------------------------------------------------------------------
  always_comb begin
    gnt_ok         = gnt_valid & ~reset;
    mem_chipselect = gnt_ok;
    mem_write      = gnt_ok & wr_vec[gnt_id];
    mem_address    = addr_arr[gnt_id];
    mem_byteenable = be_arr[gnt_id];
    mem_writedata  = wdata_arr[gnt_id];
    mem_clken      = ~reset;
    // A read that arrives together with a write is dropped: the write wins
    rd_accept      = gnt_ok & rd_vec[gnt_id] & ~wr_vec[gnt_id];
  end

  // -------------------------------------------------------------------------
  // Per-master request, waitrequest and read-return qualification
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign req[gi]       = rd_vec[gi] | wr_vec[gi];
    assign wait_vec[gi]  = ~(gnt_ok && (gnt_id == 1'(gi)));
    assign valid_vec[gi] = rd_pend_reg && (rd_id_reg == 1'(gi));
  end

  assign m0_waitrequest   = wait_vec[0];
  assign m1_waitrequest   = wait_vec[1];
  assign m0_readdatavalid = valid_vec[0];
  assign m1_readdatavalid = valid_vec[1];

  // RAM read data fans out unregistered; readdatavalid says whose it is
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_lms_ctr_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for lms_ctr_onchip_mem_arbiter. A behavioural RAM with
// one-cycle registered read and byte-enable writes sits on the mem_* side.
// Inputs change on the falling clock edge; outputs are checked 1 time unit
// later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_lms_ctr_onchip_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;

  logic [AW-1:0] m0_address,  m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;

  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  always #5 clk = ~clk;

  lms_ctr_onchip_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // Behavioural RAM; contents preloaded as C0DE0000 | address
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  bit            ram_loaded;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'hC0DE0000 | 32'(i);
      ram_loaded <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end
  assign mem_readdata = ram_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_address = '0; m0_byteenable = '1; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = '1; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_w0"},  m0_waitrequest,   1'b1);
    check({tag, "_w1"},  m1_waitrequest,   1'b1);
    check({tag, "_v0"},  m0_readdatavalid, 1'b0);
    check({tag, "_v1"},  m1_readdatavalid, 1'b0);
    check({tag, "_cs"},  mem_chipselect,   1'b0);
    check({tag, "_we"},  mem_write,        1'b0);
    check({tag, "_ce"},  mem_clken,        1'b0);
    $display("[%0t] %s: reset outputs checked", $time, tag);
  endtask

  initial begin
    int g, pg;

    // ---- Reset, with both masters requesting to confirm nothing is granted
    reset = 1'b1;
    idle();
    m0_read = 1'b1;
    m1_read = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_reset_outs("rst0");

    @(negedge clk);
    idle();
    reset = 1'b0;
    #1;
    check("rel_ce", mem_clken, 1'b1);
    check("rel_cs", mem_chipselect, 1'b0);
    check("rel_w0", m0_waitrequest, 1'b1);

    // ---- Test 1: m0 write 0x3FF then read it back
    @(negedge clk);
    m0_write = 1'b1; m0_address = 10'h3FF; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    #1;
    check("t1_wr_w0", m0_waitrequest, 1'b0);
    check("t1_wr_w1", m1_waitrequest, 1'b1);
    check("t1_wr_cs", mem_chipselect, 1'b1);
    check("t1_wr_we", mem_write, 1'b1);
    check("t1_wr_ad", 32'(mem_address), 32'h3FF);
    check("t1_wr_wd", mem_writedata, 32'hDEADBEEF);
    $display("[%0t] t1: m0 write 3FF=DEADBEEF", $time);

    @(negedge clk);
    m0_write = 1'b0; m0_read = 1'b1;
    #1;
    check("t1_rd_w0", m0_waitrequest, 1'b0);
    check("t1_rd_we", mem_write, 1'b0);
    check("t1_rd_v0", m0_readdatavalid, 1'b0);
    $display("[%0t] t1: m0 read 3FF", $time);

    @(negedge clk);
    idle();
    #1;
    check("t1_ret_v0", m0_readdatavalid, 1'b1);
    check("t1_ret_v1", m1_readdatavalid, 1'b0);
    check("t1_ret_d",  m0_readdata, 32'hDEADBEEF);
    $display("[%0t] t1: m0 readdata %h", $time, m0_readdata);

    @(negedge clk);
    #1;
    check("t1_once_v0", m0_readdatavalid, 1'b0);
    check("t1_once_v1", m1_readdatavalid, 1'b0);

    // ---- Re-reset so test 2 starts from reset state
    @(negedge clk);
    reset = 1'b1;
    #1 chk_reset_outs("rst1");

    // ---- Test 2: continuous contention from reset -> m0 x4, m1 x4, m0 x4
    @(negedge clk);
    reset = 1'b0;
    m0_read = 1'b1; m0_address = 10'h3FF;
    m1_read = 1'b1; m1_address = 10'h010;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      g = (k / 4) % 2;
      check("t2_w0", m0_waitrequest, (g != 0));
      check("t2_w1", m1_waitrequest, (g != 1));
      check("t2_ad", 32'(mem_address), (g == 1) ? 32'h010 : 32'h3FF);
      if (k == 0) begin
        check("t2_v0_first", m0_readdatavalid, 1'b0);
        check("t2_v1_first", m1_readdatavalid, 1'b0);
      end else begin
        pg = ((k - 1) / 4) % 2;
        check("t2_v0", m0_readdatavalid, (pg == 0));
        check("t2_v1", m1_readdatavalid, (pg == 1));
        check("t2_d",  m0_readdata, (pg == 1) ? 32'hC0DE0010 : 32'hDEADBEEF);
      end
      $display("[%0t] t2: cycle %0d grant m%0d", $time, k, g);
    end
    @(negedge clk);
    idle();
    #1;
    check("t2_tail_v0", m0_readdatavalid, 1'b1);
    check("t2_tail_v1", m1_readdatavalid, 1'b0);
    check("t2_tail_d",  m0_readdata, 32'hDEADBEEF);

    // ---- Test 3: m0 alone streams 10 reads with no wait cycles
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      m0_read = 1'b1; m0_address = 10'(k);
      #1;
      check("t3_w0", m0_waitrequest, 1'b0);
      if (k > 0) begin
        check("t3_v0", m0_readdatavalid, 1'b1);
        check("t3_d",  m0_readdata, 32'hC0DE0000 | 32'(k - 1));
      end
      $display("[%0t] t3: m0 read addr %0d", $time, k);
    end
    @(negedge clk);
    idle();
    #1;
    check("t3_last_v0", m0_readdatavalid, 1'b1);
    check("t3_last_d",  m0_readdata, 32'hC0DE0009);
    @(negedge clk);
    #1;
    check("t3_end_v0", m0_readdatavalid, 1'b0);

    // ---- Test 4: m1 partial write over 0xAAAAAAAA, m0 reads it back
    @(negedge clk);
    m1_write = 1'b1; m1_address = 10'd5; m1_writedata = 32'hAAAAAAAA; m1_byteenable = 4'hF;
    #1;
    check("t4_full_w1", m1_waitrequest, 1'b0);
    $display("[%0t] t4: m1 write 5=AAAAAAAA", $time);
    @(negedge clk);
    m1_writedata = 32'h11223344; m1_byteenable = 4'b0101;
    #1;
    check("t4_part_w1", m1_waitrequest, 1'b0);
    check("t4_part_be", 32'(mem_byteenable), 32'h5);
    $display("[%0t] t4: m1 write 5=11223344 be=0101", $time);
    @(negedge clk);
    idle();
    m0_read = 1'b1; m0_address = 10'd5;
    #1;
    check("t4_rd_w0", m0_waitrequest, 1'b0);
    @(negedge clk);
    idle();
    #1;
    check("t4_v0", m0_readdatavalid, 1'b1);
    check("t4_d",  m0_readdata, 32'hAA22AA44);
    $display("[%0t] t4: m0 readback %h", $time, m0_readdata);

    // ---- Test 5: read and write together -> write wins, no response
    @(negedge clk);
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 10'd7; m0_writedata = 32'h1; m0_byteenable = 4'hF;
    #1;
    check("t5_w0", m0_waitrequest, 1'b0);
    check("t5_we", mem_write, 1'b1);
    check("t5_cs", mem_chipselect, 1'b1);
    $display("[%0t] t5: m0 read+write 7=1", $time);
    @(negedge clk);
    m0_write = 1'b0;
    #1;
    check("t5_noresp_v0", m0_readdatavalid, 1'b0);
    check("t5_rd_w0", m0_waitrequest, 1'b0);
    @(negedge clk);
    idle();
    #1;
    check("t5_v0", m0_readdatavalid, 1'b1);
    check("t5_d",  m0_readdata, 32'h1);
    $display("[%0t] t5: m0 readback %h", $time, m0_readdata);

    // ---- Test 6: reset right after an accepted m1 read drops its response
    @(negedge clk);
    m1_read = 1'b1; m1_address = 10'h010;
    #1;
    check("t6_w1", m1_waitrequest, 1'b0);
    $display("[%0t] t6: m1 read 010 accepted", $time);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m0_read = 1'b1; m0_address = 10'h3FF;
    #1 chk_reset_outs("t6_rst_a");
    @(negedge clk);
    #1 chk_reset_outs("t6_rst_b");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rel_w0", m0_waitrequest, 1'b0);
    check("t6_rel_w1", m1_waitrequest, 1'b1);
    check("t6_rel_v1", m1_readdatavalid, 1'b0);
    $display("[%0t] t6: contention after reset", $time);
    @(negedge clk);
    idle();
    #1;
    check("t6_ret_v0", m0_readdatavalid, 1'b1);
    check("t6_ret_v1", m1_readdatavalid, 1'b0);
    check("t6_ret_d",  m0_readdata, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
